// File: rtl/dmac_multi_cfg_if.sv
`default_nettype none
// ============================================================================
// Module  : dmac_multi_cfg_if
// Brief   : APB register-bus bundle for the multi-channel DMA configurator.
// Revision: 1.0 - initial release
// ============================================================================
interface dmac_multi_cfg_if;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [11:0] paddr_i;
    logic [31:0] pwdata_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface
`default_nettype wire

// File: rtl/dmac_multi_cfg.sv
`default_nettype none
// ============================================================================
// Module  : dmac_multi_cfg
// Brief   : APB-programmed configuration/sequencing block for N_CH DMA
//           channels; optional interrupt logic under DMAC_MULTI_CFG_IRQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dmac_multi_cfg #(
    parameter int N_CH  = 4,
    parameter int LEN_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    dmac_multi_cfg_if.slave        apb,
    output logic [N_CH*32-1:0]     src_addr_o,
    output logic [N_CH*32-1:0]     dst_addr_o,
    output logic [N_CH*LEN_W-1:0]  byte_len_o,
    output logic [N_CH-1:0]        start_o,
    input  wire logic [N_CH-1:0]   done_i,
    output logic                   irq_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [31:0] C_VERSION  = 32'h0002_2024;
    localparam logic [4:0]  C_OFF_SRC  = 5'h00;
    localparam logic [4:0]  C_OFF_DST  = 5'h04;
    localparam logic [4:0]  C_OFF_LEN  = 5'h08;
    localparam logic [4:0]  C_OFF_CMD  = 5'h0C;
    localparam logic [4:0]  C_OFF_STAT = 5'h10;
    localparam logic [7:0]  C_GLB_VER  = 8'h00;
    localparam logic [7:0]  C_GLB_ISTA = 8'h04;
    localparam logic [7:0]  C_GLB_IEN  = 8'h08;
    localparam logic [6:0]  C_N_CH     = 7'(N_CH);

    // ---------------- APB decode ----------------
    logic        w_wr;
    logic        w_access;
    logic        w_rd_setup;
    logic        w_in_ch_space;
    logic [6:0]  w_ch_idx;
    logic [4:0]  w_off;
    logic [7:0]  w_glob_off;
    logic        w_off_ok;
    logic        w_ch_ok;
    logic        w_glob_ok;

    assign w_wr          = apb.psel_i && apb.penable_i && apb.pwrite_i;
    assign w_access      = apb.psel_i && apb.penable_i;
    assign w_rd_setup    = apb.psel_i && !apb.penable_i && !apb.pwrite_i;
    assign w_in_ch_space = (apb.paddr_i[11:8] != 4'h0);
    // Channel windows start at 0x100 and are 0x20 apart.
    assign w_ch_idx      = apb.paddr_i[11:5] - 7'd8;
    assign w_off         = apb.paddr_i[4:0];
    assign w_glob_off    = apb.paddr_i[7:0];
    assign w_off_ok      = (w_off == C_OFF_SRC) || (w_off == C_OFF_DST) ||
                           (w_off == C_OFF_LEN) || (w_off == C_OFF_CMD) ||
                           (w_off == C_OFF_STAT);
    assign w_ch_ok       = w_in_ch_space && (w_ch_idx < C_N_CH) && w_off_ok;
    assign w_glob_ok     = !w_in_ch_space &&
                           ((w_glob_off == C_GLB_VER) || (w_glob_off == C_GLB_ISTA) ||
                            (w_glob_off == C_GLB_IEN));

    // ---------------- per-channel storage ----------------
    logic [31:0]      r_src [N_CH];
    logic [31:0]      r_dst [N_CH];
    logic [LEN_W-1:0] r_len [N_CH];
    logic [N_CH-1:0]  r_done;
    state_t           r_state     [N_CH];
    state_t           w_state_nxt [N_CH];

    logic [N_CH-1:0]  w_ch_sel;
    logic [N_CH-1:0]  w_busy;
    logic [N_CH-1:0]  w_wr_ch;
    logic [N_CH-1:0]  w_cfg_wr;
    logic [N_CH-1:0]  w_cmd_go;
    logic [N_CH-1:0]  w_start;
    logic [N_CH-1:0]  w_done_evt;
    logic [N_CH-1:0]  w_err_ch;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_ch_sel[c]   = w_ch_ok && (w_ch_idx == 7'(c));
            w_busy[c]     = (r_state[c] == S_BUSY);
            w_wr_ch[c]    = w_wr && w_ch_sel[c];
            // STATUS is read-only, so a write there is neither an error nor an update.
            w_cfg_wr[c]   = w_wr_ch[c] && !w_busy[c] && (w_off != C_OFF_STAT);
            w_err_ch[c]   = w_wr_ch[c] &&  w_busy[c] && (w_off != C_OFF_STAT);
            w_cmd_go[c]   = w_cfg_wr[c] && (w_off == C_OFF_CMD) && apb.pwdata_i[0];
            w_start[c]    = w_cmd_go[c] && (r_len[c] != '0);
            w_done_evt[c] = (w_cmd_go[c] && (r_len[c] == '0)) ||
                            (w_busy[c] && done_i[c]);
        end
    end

    // ---------------- channel FSMs ----------------
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            case (r_state[c])
                S_IDLE:  if (w_start[c]) w_state_nxt[c] = S_BUSY;
                S_BUSY:  if (done_i[c])  w_state_nxt[c] = S_IDLE;
                default: w_state_nxt[c] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) r_state[c] <= S_IDLE;
        end else begin
            for (int c = 0; c < N_CH; c++) r_state[c] <= w_state_nxt[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_src[c] <= '0;
                r_dst[c] <= '0;
                r_len[c] <= '0;
            end
            r_done <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_cfg_wr[c] && (w_off == C_OFF_SRC)) r_src[c] <= apb.pwdata_i;
                if (w_cfg_wr[c] && (w_off == C_OFF_DST)) r_dst[c] <= apb.pwdata_i;
                if (w_cfg_wr[c] && (w_off == C_OFF_LEN)) r_len[c] <= apb.pwdata_i[LEN_W-1:0];
                if (w_start[c])         r_done[c] <= 1'b0;
                else if (w_done_evt[c]) r_done[c] <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_pack
        assign src_addr_o[32*c +: 32]       = r_src[c];
        assign dst_addr_o[32*c +: 32]       = r_dst[c];
        assign byte_len_o[LEN_W*c +: LEN_W] = r_len[c];
    end

    assign start_o = w_start;

    // ---------------- interrupt block ----------------
    logic [31:0] w_irq_stat_rd;
    logic [31:0] w_irq_en_rd;

`ifdef DMAC_MULTI_CFG_IRQ_EN
    logic [N_CH-1:0] r_irq_stat;
    logic [N_CH-1:0] r_irq_en;
    logic [N_CH-1:0] w_w1c;

    assign w_w1c = (w_wr && w_glob_ok && (w_glob_off == C_GLB_ISTA)) ?
                   apb.pwdata_i[N_CH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_stat <= '0;
            r_irq_en   <= '0;
        end else begin
            // New completion events win over a same-cycle clear.
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_done_evt;
            if (w_wr && w_glob_ok && (w_glob_off == C_GLB_IEN))
                r_irq_en <= apb.pwdata_i[N_CH-1:0];
        end
    end

    assign irq_o         = |(r_irq_stat & r_irq_en);
    assign w_irq_stat_rd = 32'(r_irq_stat);
    assign w_irq_en_rd   = 32'(r_irq_en);
`else
    assign irq_o         = 1'b0;
    assign w_irq_stat_rd = 32'h0;
    assign w_irq_en_rd   = 32'h0;
`endif

    // ---------------- read path ----------------
    logic [31:0] w_rd_data;
    logic [31:0] r_rdata;

    always_comb begin
        w_rd_data = 32'h0;
        if (w_glob_ok) begin
            case (w_glob_off)
                C_GLB_VER:  w_rd_data = C_VERSION;
                C_GLB_ISTA: w_rd_data = w_irq_stat_rd;
                C_GLB_IEN:  w_rd_data = w_irq_en_rd;
                default:    w_rd_data = 32'h0;
            endcase
        end
        for (int c = 0; c < N_CH; c++) begin
            if (w_ch_sel[c]) begin
                case (w_off)
                    C_OFF_SRC:  w_rd_data = r_src[c];
                    C_OFF_DST:  w_rd_data = r_dst[c];
                    C_OFF_LEN:  w_rd_data = 32'(r_len[c]);
                    C_OFF_STAT: w_rd_data = {30'h0, w_busy[c], r_done[c]};
                    default:    w_rd_data = 32'h0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_rdata <= 32'h0;
        else if (w_rd_setup) r_rdata <= w_rd_data;
    end

    assign apb.prdata_o  = r_rdata;
    assign apb.pready_o  = 1'b1;
    // Gated by rst_n so a bus access held during reset never reports an error.
    assign apb.pslverr_o = rst_n && w_access && (!(w_ch_ok || w_glob_ok) || (|w_err_ch));

endmodule
`default_nettype wire

// File: tb/tb_dmac_multi_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmac_multi_cfg
// Brief   : Self-checking bench: directed vector table, hand sequences and
//           random traffic against a register-level model of the block.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmac_multi_cfg;
    localparam int N_CH  = 4;
    localparam int LEN_W = 16;
    localparam logic [31:0] LEN_MASK = 32'h0000_FFFF;
`ifdef DMAC_MULTI_CFG_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_CH*32-1:0]     src_addr_o;
    logic [N_CH*32-1:0]     dst_addr_o;
    logic [N_CH*LEN_W-1:0]  byte_len_o;
    logic [N_CH-1:0]        start_o;
    logic [N_CH-1:0]        done_i = '0;
    logic                   irq_o;

    dmac_multi_cfg_if apb();

    dmac_multi_cfg #(.N_CH(N_CH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .apb        (apb),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .byte_len_o (byte_len_o),
        .start_o    (start_o),
        .done_i     (done_i),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0]     m_src [N_CH];
    logic [31:0]     m_dst [N_CH];
    logic [31:0]     m_len [N_CH];
    logic [N_CH-1:0] m_busy, m_done, m_stat, m_en;

    function automatic void m_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0;
        end
        m_busy = 0; m_done = 0; m_stat = 0; m_en = 0;
    endfunction

    function automatic void m_decode(input logic [11:0] a, output int ch, output int off, output bit ok);
        int ai;
        ai = int'({20'd0, a});
        if (ai < 'h100) begin
            ch = -1; off = ai; ok = (ai == 0) || (ai == 4) || (ai == 8);
        end else begin
            ch  = (ai - 'h100) / 'h20;
            off = (ai - 'h100) % 'h20;
            ok  = (ch < N_CH) && (off == 0 || off == 4 || off == 8 || off == 12 || off == 16);
        end
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] d,
                                    output bit err, output logic [N_CH-1:0] st);
        int ch, off; bit ok;
        m_decode(a, ch, off, ok);
        err = !ok; st = '0;
        if (ok && ch < 0) begin
            if (off == 4) m_stat = m_stat & ~d[N_CH-1:0];
            if (off == 8) m_en   = d[N_CH-1:0];
        end else if (ok) begin
            if (m_busy[ch] && off != 16) err = 1'b1;
            else begin
                case (off)
                    0:  m_src[ch] = d;
                    4:  m_dst[ch] = d;
                    8:  m_len[ch] = d & LEN_MASK;
                    12: if (d[0]) begin
                            if (m_len[ch] != 0) begin
                                m_busy[ch] = 1'b1; m_done[ch] = 1'b0; st[ch] = 1'b1;
                            end else begin
                                m_done[ch] = 1'b1; m_stat[ch] = 1'b1;
                            end
                        end
                    default: ;
                endcase
            end
        end
    endfunction

    function automatic void m_read(input logic [11:0] a, output logic [31:0] d, output bit err);
        int ch, off; bit ok;
        m_decode(a, ch, off, ok);
        err = !ok; d = 0;
        if (ok && ch < 0) begin
            if (off == 0) d = 32'h0002_2024;
            if (off == 4) d = IRQ_ON ? 32'(m_stat) : 32'h0;
            if (off == 8) d = IRQ_ON ? 32'(m_en)   : 32'h0;
        end else if (ok) begin
            case (off)
                0:  d = m_src[ch];
                4:  d = m_dst[ch];
                8:  d = m_len[ch];
                16: d = {30'd0, m_busy[ch], m_done[ch]};
                default: d = 0;
            endcase
        end
    endfunction

    function automatic logic m_irq();
        return IRQ_ON && (|(m_stat & m_en));
    endfunction

    function automatic void m_done_evt(input logic [N_CH-1:0] ev);
        m_busy = m_busy & ~ev;
        m_done = m_done | ev;
        m_stat = m_stat | ev;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic do_op(input bit wr, input logic [11:0] a, input logic [31:0] d,
                         input logic [N_CH-1:0] dm, output logic [31:0] rd,
                         output bit err_act, output logic [N_CH-1:0] st_act);
        bit e_err; logic [31:0] e_rd; logic [N_CH-1:0] e_st, dev;
        @(posedge clk); #1;
        apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
        apb.paddr_i = a; apb.pwdata_i = d;
        @(posedge clk); #1;
        apb.penable_i = 1'b1; done_i = dm;
        dev = dm & m_busy;
        e_rd = 0;
        if (wr) m_write(a, d, e_err, e_st);
        else begin m_read(a, e_rd, e_err); e_st = '0; end
        #1;
        err_act = apb.pslverr_o; st_act = start_o; rd = apb.prdata_o;
        check($sformatf("pslverr %s@%03h", wr ? "W" : "R", a), 32'(err_act), 32'(e_err));
        check($sformatf("start_o @%03h", a), 32'(st_act), 32'(e_st));
        if (!wr) check($sformatf("prdata @%03h", a), rd, e_rd);
        @(posedge clk); #1;
        apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0; done_i = '0;
        m_done_evt(dev);
        check("start_o idle", 32'(start_o), 32'h0);
        check("irq_o", 32'(irq_o), 32'(m_irq()));
    endtask

    task automatic pulse_done(input logic [N_CH-1:0] m);
        logic [N_CH-1:0] dev;
        @(posedge clk); #1;
        done_i = m; dev = m & m_busy;
        @(posedge clk); #1;
        done_i = '0;
        m_done_evt(dev);
        check("irq_o after done", 32'(irq_o), 32'(m_irq()));
    endtask

    task automatic check_reset_outputs();
        apb.psel_i = 1'b1; apb.penable_i = 1'b1; apb.pwrite_i = 1'b0; apb.paddr_i = 12'hFFC;
        #1;
        check("rst pslverr", 32'(apb.pslverr_o), 32'h0);
        check("rst prdata", apb.prdata_o, 32'h0);
        check("rst start_o", 32'(start_o), 32'h0);
        check("rst irq_o", 32'(irq_o), 32'h0);
        check("rst cfg outputs", 32'((|src_addr_o) | (|dst_addr_o) | (|byte_len_o)), 32'h0);
        apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit              wr;
        logic [11:0]     addr;
        logic [31:0]     data;
        bit              chk_rd;
        logic [31:0]     exp_rd;
        bit              exp_err;
        logic [N_CH-1:0] exp_start;
    } vec_t;

    vec_t vt [18];

    logic [31:0]     rd;
    bit              err;
    logic [N_CH-1:0] st;
    int              offs [7];
    logic [31:0]     rnd;
    int              kind, rch;
    logic [11:0]     ra;
    logic [31:0]     rdat;

    initial begin
        apb.psel_i = 0; apb.penable_i = 0; apb.pwrite_i = 0; apb.paddr_i = 0; apb.pwdata_i = 0;
        m_reset();
        offs = '{0, 4, 8, 12, 16, 20, 28};

        vt[0]  = '{1, 12'h120, 32'h1000_0000, 0, 32'h0,          0, 4'b0000};
        vt[1]  = '{1, 12'h124, 32'h2000_0000, 0, 32'h0,          0, 4'b0000};
        vt[2]  = '{1, 12'h128, 32'h0000_0040, 0, 32'h0,          0, 4'b0000};
        vt[3]  = '{0, 12'h120, 32'h0,         1, 32'h1000_0000,  0, 4'b0000};
        vt[4]  = '{0, 12'h124, 32'h0,         1, 32'h2000_0000,  0, 4'b0000};
        vt[5]  = '{0, 12'h128, 32'h0,         1, 32'h0000_0040,  0, 4'b0000};
        vt[6]  = '{0, 12'h000, 32'h0,         1, 32'h0002_2024,  0, 4'b0000};
        vt[7]  = '{1, 12'h148, 32'h0000_0080, 0, 32'h0,          0, 4'b0000};
        vt[8]  = '{1, 12'h14C, 32'h0000_0001, 0, 32'h0,          0, 4'b0100};
        vt[9]  = '{0, 12'h150, 32'h0,         1, 32'h0000_0002,  0, 4'b0000};
        vt[10] = '{1, 12'h148, 32'h0000_0055, 0, 32'h0,          1, 4'b0000};
        vt[11] = '{0, 12'h148, 32'h0,         1, 32'h0000_0080,  0, 4'b0000};
        vt[12] = '{1, 12'h16C, 32'h0000_0001, 0, 32'h0,          0, 4'b0000};
        vt[13] = '{0, 12'h170, 32'h0,         1, 32'h0000_0001,  0, 4'b0000};
        vt[14] = '{0, 12'h180, 32'h0,         1, 32'h0,          1, 4'b0000};
        vt[15] = '{0, 12'h014, 32'h0,         1, 32'h0,          1, 4'b0000};
        vt[16] = '{1, 12'h108, 32'h0001_2345, 0, 32'h0,          0, 4'b0000};
        vt[17] = '{0, 12'h108, 32'h0,         1, 32'h0000_2345,  0, 4'b0000};

        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        #2 rst_n = 1'b1;
        check("pready", 32'(apb.pready_o), 32'h1);

        for (int i = 0; i < 18; i++) begin
            do_op(vt[i].wr, vt[i].addr, vt[i].data, '0, rd, err, st);
            check($sformatf("vec%0d err", i), 32'(err), 32'(vt[i].exp_err));
            check($sformatf("vec%0d start", i), 32'(st), 32'(vt[i].exp_start));
            if (vt[i].chk_rd) check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
        end
        check("src_addr_o ch1", src_addr_o[63:32], 32'h1000_0000);
        check("byte_len_o ch2", 32'(byte_len_o[47:32]), 32'h80);

        // Interrupt status set/clear and set-wins-over-clear.
        do_reset();
        do_op(1, 12'h008, 32'hF, '0, rd, err, st);
        do_op(1, 12'h108, 32'h4, '0, rd, err, st);
        do_op(1, 12'h148, 32'h8, '0, rd, err, st);
        do_op(1, 12'h10C, 32'h1, '0, rd, err, st);
        do_op(1, 12'h14C, 32'h1, '0, rd, err, st);
        pulse_done(4'b0101);
        do_op(0, 12'h004, 32'h0, '0, rd, err, st);
        check("irq_stat after done", rd, IRQ_ON ? 32'h5 : 32'h0);
        check("irq_o after done pair", 32'(irq_o), 32'(IRQ_ON));
        do_op(0, 12'h150, 32'h0, '0, rd, err, st);
        check("ch2 status done", rd, 32'h1);
        do_op(1, 12'h004, 32'h1, '0, rd, err, st);
        do_op(0, 12'h004, 32'h0, '0, rd, err, st);
        check("irq_stat after w1c", rd, IRQ_ON ? 32'h4 : 32'h0);
        do_op(1, 12'h004, 32'h4, '0, rd, err, st);
        check("irq_o cleared", 32'(irq_o), 32'h0);
        do_op(1, 12'h10C, 32'h1, '0, rd, err, st);
        do_op(1, 12'h004, 32'h1, 4'b0001, rd, err, st);
        do_op(0, 12'h004, 32'h0, '0, rd, err, st);
        check("set wins over w1c", rd, IRQ_ON ? 32'h1 : 32'h0);

        // Reset while channel 3 is busy.
        do_op(1, 12'h168, 32'h5, '0, rd, err, st);
        do_op(1, 12'h16C, 32'h1, '0, rd, err, st);
        check("ch3 start", 32'(st), 32'h8);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("start_o after reset", 32'(start_o), 32'h0);
        end
        do_op(0, 12'h170, 32'h0, '0, rd, err, st);
        check("ch3 status after reset", rd, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                rnd = $urandom;
                pulse_done(rnd[N_CH-1:0]);
            end else begin
                rch = $urandom_range(0, N_CH);
                if (kind == 2) ra = 12'(4 * $urandom_range(0, 3));
                else ra = 12'(32'h100 + 32 * rch + offs[$urandom_range(0, 6)]);
                rdat = $urandom;
                if (ra[4:0] == 5'h08 && ra >= 12'h100) begin
                    if ($urandom_range(0, 2) == 0) rdat = 0;
                    else rdat = rdat & 32'h0001_00FF;
                end
                do_op(1'($urandom_range(0, 1)), ra, rdat, '0, rd, err, st);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
